// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg: shared encodings and widths for the mini CPU run controller
package mini_cpu_pkg;
    localparam int IMEM_AW = 8;
    localparam int IMEM_DW = 16;
    localparam int RF_AW = 2;
    localparam int RF_DW = 8;
    typedef enum logic [1:0] {OP_LOAD_IMEM = 2'd0, OP_LOAD_REG = 2'd1, OP_RUN = 2'd2, OP_ABORT = 2'd3} cmd_op_t;
    typedef enum logic [1:0] {ST_NONE = 2'd0, ST_HALTED = 2'd1, ST_TIMEOUT = 2'd2, ST_ABORTED = 2'd3} run_status_t;
    typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/cycle_timeout_cnt.sv
// cycle_timeout_cnt: saturating run-cycle counter flagging the increment that reaches max
module cycle_timeout_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         expired
);
    assign expired = en && count == max - W'(1);
    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else if (en && count != '1) count <= count + W'(1);
endmodule

// File: rtl/mini_cpu_run_ctrl.sv
// mini_cpu_run_ctrl: host command sequencer loading, running and timing the mini CPU
module mini_cpu_run_ctrl
    import mini_cpu_pkg::*;
#(
    parameter int MAX_CYCLES = 200,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [IMEM_AW-1:0] cmd_addr,
    input  logic [IMEM_DW-1:0] cmd_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [IMEM_DW-1:0] imem_wdata,
    output logic               rf_we,
    output logic [RF_AW-1:0]   rf_addr,
    output logic [RF_DW-1:0]   rf_wdata,
    output logic               cpu_en,
    input  logic               cpu_halt,
    output logic               busy,
    output logic               run_done,
    output logic [1:0]         run_status,
    output logic [CNT_W-1:0]   run_cycles
);
    state_t state, state_n;
    logic acc, idle_acc, ld_imem, ld_reg, go, exit_run, expired;
    logic imem_we_n, rf_we_n, cpu_en_n, run_done_n;
    logic [IMEM_AW-1:0] imem_addr_n;
    logic [IMEM_DW-1:0] imem_wdata_n;
    logic [RF_AW-1:0] rf_addr_n;
    logic [RF_DW-1:0] rf_wdata_n;
    logic [1:0] status_n;
    assign cmd_ready = !rst && (state == S_IDLE || (state == S_RUN && cmd_op == OP_ABORT));
    assign acc = cmd_valid && cmd_ready;
    always_comb begin
        idle_acc = state == S_IDLE && acc;
        ld_imem = idle_acc && cmd_op == OP_LOAD_IMEM;
        ld_reg = idle_acc && cmd_op == OP_LOAD_REG;
        go = idle_acc && cmd_op == OP_RUN;
        exit_run = state == S_RUN && (cpu_halt || acc || expired);
        state_n = go ? S_RUN
                : (ld_imem || ld_reg) ? S_WR
                : state == S_WR ? S_GAP
                : state == S_GAP ? S_IDLE
                : exit_run ? S_DONE
                : state == S_DONE ? S_IDLE
                : state;
        status_n = go ? ST_NONE
                 : state != S_RUN ? run_status
                 : cpu_halt ? ST_HALTED
                 : acc ? ST_ABORTED
                 : expired ? ST_TIMEOUT
                 : run_status;
        cpu_en_n = go || (state == S_RUN && !exit_run);
        run_done_n = exit_run;
        imem_we_n = ld_imem;
        rf_we_n = ld_reg;
        imem_addr_n = ld_imem ? cmd_addr : imem_addr;
        imem_wdata_n = ld_imem ? cmd_data : imem_wdata;
        rf_addr_n = ld_reg ? cmd_addr[RF_AW-1:0] : rf_addr;
        rf_wdata_n = ld_reg ? cmd_data[RF_DW-1:0] : rf_wdata;
    end
    always_ff @(posedge clk)
        if (rst) begin
            state <= S_IDLE;
            imem_we <= 1'b0;
            imem_addr <= '0;
            imem_wdata <= '0;
            rf_we <= 1'b0;
            rf_addr <= '0;
            rf_wdata <= '0;
            cpu_en <= 1'b0;
            busy <= 1'b0;
            run_done <= 1'b0;
            run_status <= ST_NONE;
        end else begin
            state <= state_n;
            imem_we <= imem_we_n;
            imem_addr <= imem_addr_n;
            imem_wdata <= imem_wdata_n;
            rf_we <= rf_we_n;
            rf_addr <= rf_addr_n;
            rf_wdata <= rf_wdata_n;
            cpu_en <= cpu_en_n;
            busy <= state_n != S_IDLE;
            run_done <= run_done_n;
            run_status <= status_n;
        end
    cycle_timeout_cnt #(.W(CNT_W)) u_cnt (
        .clk(clk),
        .rst(rst),
        .en(state == S_RUN && cpu_en && !cpu_halt),
        .clr(go),
        .max(CNT_W'(MAX_CYCLES)),
        .count(run_cycles),
        .expired(expired)
    );
endmodule
